// File: rtl/lat_test_seq.sv
// Sequencer for lat_tester: runs 2^n latency samples (arm, fire on a dark frame
// start, wait for light, capture) and keeps min/max/average of the results.
module lat_test_seq #(
  parameter int SETTLE_CYC   = 16,
  parameter int STUCK_FRAMES = 8,
  parameter int CAP_DLY      = 2
) (
  input  logic        clk27,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  samples_log2,
  input  logic [3:0]  holdoff_frames,
  input  logic        VSYNC_in,
  input  logic        sensor,
  input  logic [15:0] lt_result,
  output logic        lt_active,
  output logic        lt_armed,
  output logic        lt_trigger,
  output logic        patch_en,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error,
  output logic [4:0]  sample_cnt,
  output logic [15:0] lat_min,
  output logic [15:0] lat_max,
  output logic [15:0] lat_avg
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WAIT_FRAME, S_FIRE, S_MEASURE, S_CAPTURE, S_HOLDOFF
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] STUCK_LAST  = 8'(STUCK_FRAMES - 1);
  localparam logic [7:0] CAP_LAST    = 8'(CAP_DLY - 1);

  state_t      state_q;
  logic [2:0]  vs_q;
  logic        frame_start;
  logic [7:0]  settle_ctr_q, stuck_ctr_q, cap_ctr_q;
  logic [3:0]  hold_ctr_q, hold_frames_q;
  logic        seen_dark_q;
  logic [2:0]  n_eff_q, n_eff_d;
  logic        active_q, armed_q, trigger_q, patch_q, done_q;
  logic [1:0]  error_q;
  logic [4:0]  cnt_q, cnt_d;
  logic [19:0] sum_q, sum_d, avg_shift;
  logic [15:0] min_q, min_d, max_q, max_d, avg_q, avg_d;
  logic        last_sample;

  // Frame start is the falling edge of the synchronized (active-low) vsync.
  assign frame_start = vs_q[2] & ~vs_q[1];

  always_comb begin
    n_eff_d     = (samples_log2 > 3'd4) ? 3'd4 : samples_log2;
    sum_d       = sum_q + {4'b0, lt_result};
    min_d       = (lt_result < min_q) ? lt_result : min_q;
    max_d       = (lt_result > max_q) ? lt_result : max_q;
    cnt_d       = cnt_q + 5'd1;
    avg_shift   = sum_d >> n_eff_q;
    avg_d       = avg_shift[15:0];
    last_sample = (cnt_d == (5'd1 << n_eff_q));
  end

  always_ff @(posedge clk27) begin
    if (reset) begin
      state_q       <= S_IDLE;
      vs_q          <= 3'b0;
      settle_ctr_q  <= 8'd0;
      stuck_ctr_q   <= 8'd0;
      cap_ctr_q     <= 8'd0;
      hold_ctr_q    <= 4'd0;
      hold_frames_q <= 4'd0;
      seen_dark_q   <= 1'b0;
      n_eff_q       <= 3'd0;
      active_q      <= 1'b0;
      armed_q       <= 1'b0;
      trigger_q     <= 1'b0;
      patch_q       <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 2'd0;
      cnt_q         <= 5'd0;
      sum_q         <= 20'd0;
      min_q         <= 16'hffff;
      max_q         <= 16'd0;
      avg_q         <= 16'd0;
    end else begin
      vs_q <= {vs_q[1:0], VSYNC_in};
      // Abort overrides every other transition; completed-sample stats survive.
      if (state_q != S_IDLE && abort) begin
        state_q   <= S_IDLE;
        error_q   <= 2'd3;
        patch_q   <= 1'b0;
        armed_q   <= 1'b0;
        trigger_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              done_q        <= 1'b0;
              error_q       <= 2'd0;
              cnt_q         <= 5'd0;
              sum_q         <= 20'd0;
              min_q         <= 16'hffff;
              max_q         <= 16'd0;
              avg_q         <= 16'd0;
              n_eff_q       <= n_eff_d;
              hold_frames_q <= holdoff_frames;
              active_q      <= 1'b1;
              armed_q       <= 1'b1;
              settle_ctr_q  <= 8'd0;
              stuck_ctr_q   <= 8'd0;
              state_q       <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (settle_ctr_q == SETTLE_LAST) state_q <= S_WAIT_FRAME;
            else settle_ctr_q <= settle_ctr_q + 8'd1;
          end
          S_WAIT_FRAME: begin
            if (frame_start) begin
              if (sensor) begin
                trigger_q <= 1'b1;
                patch_q   <= 1'b1;
                state_q   <= S_FIRE;
              end else if (stuck_ctr_q == STUCK_LAST) begin
                error_q <= 2'd2;
                armed_q <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                stuck_ctr_q <= stuck_ctr_q + 8'd1;
              end
            end
          end
          S_FIRE: begin
            trigger_q   <= 1'b0;
            stuck_ctr_q <= 8'd0;
            state_q     <= S_MEASURE;
          end
          S_MEASURE: begin
            if (!sensor || lt_result == 16'hffff) begin
              if (lt_result == 16'hffff) error_q <= 2'd1;
              patch_q   <= 1'b0;
              cap_ctr_q <= 8'd0;
              state_q   <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            // Give the tester's last increment time to land before latching.
            if (cap_ctr_q == CAP_LAST) begin
              min_q   <= min_d;
              max_q   <= max_d;
              sum_q   <= sum_d;
              cnt_q   <= cnt_d;
              avg_q   <= avg_d;
              armed_q <= 1'b0;
              if (error_q == 2'd1) begin
                state_q <= S_IDLE;
              end else if (last_sample) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                seen_dark_q <= 1'b0;
                hold_ctr_q  <= 4'd0;
                state_q     <= S_HOLDOFF;
              end
            end else begin
              cap_ctr_q <= cap_ctr_q + 8'd1;
            end
          end
          S_HOLDOFF: begin
            if (seen_dark_q || sensor) begin
              seen_dark_q <= 1'b1;
              if (hold_ctr_q == hold_frames_q) begin
                armed_q      <= 1'b1;
                settle_ctr_q <= 8'd0;
                state_q      <= S_SETTLE;
              end else if (frame_start) begin
                hold_ctr_q <= hold_ctr_q + 4'd1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign lt_active  = active_q;
  assign lt_armed   = armed_q;
  assign lt_trigger = trigger_q;
  assign patch_en   = patch_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign error      = error_q;
  assign sample_cnt = cnt_q;
  assign lat_min    = (cnt_q == 5'd0) ? 16'h0 : min_q;
  assign lat_max    = max_q;
  assign lat_avg    = avg_q;

endmodule
